// File: rtl/fp_pkg.sv
// Shared constants, FSM state encoding and the unpacked-operand record for the
// sequential single-precision multiplier.
package fp_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_RND  = 2'd3
  } fp_state_e;

  // Result class decided once in MUL so NORM/RND only carry a tag.
  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_mult_seq_if.sv
// Operand/result bundle between the PIO-side requester and the multiplier.
// Handshake: start is a request strobe sampled every cycle; it is accepted only
// when busy=0, operands are captured on that edge, and done pulses for one cycle
// when result updates (result then holds until the next completion).
interface fp_mult_seq_if;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output operand_a,
    output operand_b,
    output start,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  operand_a,
    input  operand_b,
    input  start,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign/exponent/significand and class flags.
// Denormals are flushed to zero here so the datapath never sees them.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]  value,
  output fp_unpacked_t unpacked
);

  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic        exp_all_ones;

  assign exp_f        = value[30:23];
  assign frac_f       = value[22:0];
  assign exp_all_ones = (exp_f == 8'(EXP_MAX));

  always_comb begin
    unpacked.sign    = value[31];
    unpacked.exp     = exp_f;
    unpacked.is_zero = (exp_f == 8'd0);
    unpacked.is_inf  = exp_all_ones && (frac_f == 23'd0);
    unpacked.is_nan  = exp_all_ones && (frac_f != 23'd0);
    unpacked.sig     = (exp_f == 8'd0) ? 24'd0 : {1'b1, frac_f};
  end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 single-precision multiplier: IDLE -> MUL -> NORM -> RND,
// one state per cycle, round-to-nearest-even, flush-to-zero on both ends.
module fp_mult_seq
  import fp_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  fp_mult_seq_if.slave     bus,
  output fp_state_e        dbg_state
);

  if (LATENCY != 3) begin : g_latency_check
    $error("fp_mult_seq supports LATENCY=3 only");
  end

  fp_state_e          state_q,  state_d;
  logic [31:0]        a_q,      a_d;
  logic [31:0]        b_q,      b_d;
  logic               sign_q,   sign_d;
  fp_class_e          cls_q,    cls_d;
  logic [47:0]        prod_q,   prod_d;
  logic signed [9:0]  exp_q,    exp_d;
  logic [23:0]        mant_q,   mant_d;
  logic               guard_q,  guard_d;
  logic               sticky_q, sticky_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [31:0]        result_q, result_d;

  fp_unpacked_t ua;
  fp_unpacked_t ub;

  fp_unpack u_unpack_a (.value(a_q), .unpacked(ua));
  fp_unpack u_unpack_b (.value(b_q), .unpacked(ub));

  // Zero-extended operands keep the product expression a full 48 bits wide.
  logic [47:0]       prod_full;
  logic signed [9:0] exp_sum;
  fp_class_e         cls_mul;

  assign prod_full = {24'd0, ua.sig} * {24'd0, ub.sig};
  assign exp_sum   = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp})
                   - $signed(10'(EXP_BIAS));

  always_comb begin
    cls_mul = CLS_NORMAL;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf))
      cls_mul = CLS_NAN;
    else if (ua.is_inf || ub.is_inf)
      cls_mul = CLS_INF;
    else if (ua.is_zero || ub.is_zero)
      cls_mul = CLS_ZERO;
  end

  logic              round_up;
  logic [24:0]       mant_sum;
  logic signed [9:0] exp_fin;
  logic [22:0]       frac_fin;
  logic [31:0]       signed_zero;
  logic [31:0]       rnd_result;

  assign round_up    = guard_q & (sticky_q | mant_q[0]);
  assign mant_sum    = {1'b0, mant_q} + {24'd0, round_up};
  assign exp_fin     = mant_sum[24] ? (exp_q + 10'sd1) : exp_q;
  assign frac_fin    = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
  assign signed_zero = {sign_q, 31'd0};

  always_comb begin
    rnd_result = {sign_q, exp_fin[7:0], frac_fin};
    case (cls_q)
      CLS_NAN:  rnd_result = QNAN;
      CLS_INF:  rnd_result = POS_INF | signed_zero;
      CLS_ZERO: rnd_result = signed_zero;
      default: begin
        if (exp_fin <= 10'sd0)
          rnd_result = signed_zero;
        else if (exp_fin >= $signed(10'(EXP_MAX)))
          rnd_result = POS_INF | signed_zero;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    cls_d    = cls_q;
    prod_d   = prod_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.operand_a;
          b_d     = bus.operand_b;
          busy_d  = 1'b1;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        sign_d  = a_q[31] ^ b_q[31];
        cls_d   = cls_mul;
        prod_d  = prod_full;
        exp_d   = exp_sum;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        // Product of two [1,2) significands lies in [1,4): at most one right shift.
        if (prod_q[47]) begin
          mant_d   = prod_q[47:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          mant_d   = prod_q[46:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = ST_RND;
      end
      ST_RND: begin
        result_d = rnd_result;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      cls_q    <= CLS_NORMAL;
      prod_q   <= '0;
      exp_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      cls_q    <= cls_d;
      prod_q   <= prod_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq: timing of busy/done, IEEE special cases,
// rounding paths, back-to-back start and mid-operation reset.
module tb_fp_mult_seq;
  import fp_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n = 1'b0;
  fp_state_e dbg_state;
  int        tests_run = 0;
  int        tests_failed = 0;

  fp_mult_seq_if bus ();

  fp_mult_seq #(.LATENCY(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts on the next edge, scrambles the operands afterwards, then checks
  // busy on edges 0..2, done+result on edge 3 and the held result on edge 4.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.operand_a = ~a;
    bus.operand_b = ~b;
    check({tag, ".busy0"}, 32'(bus.busy), 32'd1);
    check({tag, ".done0"}, 32'(bus.done), 32'd0);
    tick();
    check({tag, ".busy1"}, 32'(bus.busy), 32'd1);
    tick();
    check({tag, ".busy2"}, 32'(bus.busy), 32'd1);
    check({tag, ".done2"}, 32'(bus.done), 32'd0);
    tick();
    check({tag, ".busy3"}, 32'(bus.busy), 32'd0);
    check({tag, ".done3"}, 32'(bus.done), 32'd1);
    check({tag, ".result"}, bus.result, exp_res);
    tick();
    check({tag, ".done4"}, 32'(bus.done), 32'd0);
    check({tag, ".hold"}, bus.result, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.start     = 1'b0;
    #12;
    check("rst.state",  32'(dbg_state), 32'(ST_IDLE));
    check("rst.busy",   32'(bus.busy), 32'd0);
    check("rst.done",   32'(bus.done), 32'd0);
    check("rst.result", bus.result, 32'h0000_0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_op("mul_1p5x2",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    run_op("ovf_pos",     32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
    run_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("ninf_x_one",  32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    run_op("denorm_in",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
    run_op("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    run_op("neg_one",     32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000);
    run_op("rne_sticky",  32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    run_op("norm_shift",  32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
    run_op("rne_tie_up",  32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
    run_op("neg_half",    32'h4040_0000, 32'hBF00_0000, 32'hBFC0_0000);
    run_op("nan_in",      32'hFF80_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_op("ninf_x_inf",  32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000);
    run_op("nzero_x_5",   32'h8000_0000, 32'h40A0_0000, 32'h8000_0000);
    run_op("nzero_x_inf", 32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_op("underflow_n", 32'h8080_0000, 32'h0080_0000, 32'h8000_0000);
    run_op("ovf_neg",     32'hFF7F_FFFF, 32'h4000_0000, 32'hFF80_0000);

    // Start held high: accepted on edges 0, 4, 8; done after edges 3, 7.
    bus.operand_a = 32'h3FC0_0000;
    bus.operand_b = 32'h4000_0000;
    bus.start     = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("held.done%0d", k), 32'(bus.done), ((k == 3) || (k == 7)) ? 32'd1 : 32'd0);
      check($sformatf("held.busy%0d", k), 32'(bus.busy), ((k % 4) != 3) ? 32'd1 : 32'd0);
      if (k == 3)
        check("held.result", bus.result, 32'h4040_0000);
    end
    bus.start = 1'b0;
    tick();
    check("held.busy10", 32'(bus.busy), 32'd1);
    tick();
    check("held.done11", 32'(bus.done), 32'd1);
    check("held.busy11", 32'(bus.busy), 32'd0);
    tick();
    check("held.idle", 32'(dbg_state), 32'(ST_IDLE));

    // Reset in the middle of an operation aborts it without a done pulse.
    bus.operand_a = 32'h4040_0000;
    bus.operand_b = 32'h4000_0000;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("abort.busy_pre", 32'(bus.busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort.state",  32'(dbg_state), 32'(ST_IDLE));
    check("abort.busy",   32'(bus.busy), 32'd0);
    check("abort.done",   32'(bus.done), 32'd0);
    check("abort.result", bus.result, 32'h0000_0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("abort.nodone%0d", k), 32'(bus.done), 32'd0);
      check($sformatf("abort.res%0d", k), bus.result, 32'h0000_0000);
    end
    run_op("after_abort", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
